// File: rtl/sampling_control.sv
// Sample-rate controller: button steps a mode, mode picks a divider, divider emits a 1-cycle Enable strobe.
// Latency: Mode updates on the press edge, Ready after SETTLE_CYCLES edges, first Enable DIV edges later; no backpressure.
module sampling_control #(
    parameter int NUM_MODES     = 10,
    parameter int SETTLE_CYCLES = 8,
    parameter int DIV_W         = 18
) (
    input  logic       Fg_CLK,
    input  logic       RESETn,
    input  logic       IntBTN,
    output logic       Ready,
    output logic       Enable,
    output logic [3:0] Mode
);

    localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [3:0]        LAST_MODE   = 4'(NUM_MODES - 1);
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         mode_q, mode_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               btn_q, btn_d;
    logic               ready_q, ready_d;
    logic               enable_q, enable_d;
    logic               press;
    logic [DIV_W-1:0]   div_last;

    // Terminal count (divisor - 1) for each mode.
    function automatic logic [DIV_W-1:0] mode_div_last(input logic [3:0] m);
        logic [DIV_W-1:0] r;
        case (m)
            4'd1:    r = DIV_W'(24 - 1);
            4'd2:    r = DIV_W'(48 - 1);
            4'd3:    r = DIV_W'(240 - 1);
            4'd4:    r = DIV_W'(480 - 1);
            4'd5:    r = DIV_W'(2400 - 1);
            4'd6:    r = DIV_W'(4800 - 1);
            4'd7:    r = DIV_W'(24000 - 1);
            4'd8:    r = DIV_W'(48000 - 1);
            4'd9:    r = DIV_W'(240000 - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign press    = IntBTN & ~btn_q;
    assign div_last = mode_div_last(mode_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        settle_d = settle_q;
        div_d    = div_q;
        btn_d    = IntBTN;
        enable_d = 1'b0;

        if (press) begin
            // A press always wins over a strobe due on the same edge.
            mode_d   = (mode_q == LAST_MODE) ? 4'd0 : mode_q + 4'd1;
            settle_d = SETTLE_LOAD;
            div_d    = '0;
            state_d  = (mode_q == LAST_MODE) ? ST_OFF : ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q != '0) begin
                        settle_d = settle_q - 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (div_q == div_last) begin
                        div_d    = '0;
                        enable_d = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state_q  <= ST_OFF;
            mode_q   <= 4'd0;
            settle_q <= '0;
            div_q    <= '0;
            btn_q    <= 1'b0;
            ready_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            settle_q <= settle_d;
            div_q    <= div_d;
            btn_q    <= btn_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
        end
    end

    assign Ready  = ready_q;
    assign Enable = enable_q;
    assign Mode   = mode_q;

endmodule

// File: tb/tb_sampling_control.sv
// Directed bench for sampling_control: mode stepping, settle timing, strobe periods, wrap, reset.
module tb_sampling_control;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       ready;
    logic       enable;
    logic [3:0] mode;

    int checks = 0;
    int errors = 0;

    sampling_control #(
        .NUM_MODES    (10),
        .SETTLE_CYCLES(8),
        .DIV_W        (18)
    ) dut (
        .Fg_CLK(clk),
        .RESETn(rst_n),
        .IntBTN(btn),
        .Ready (ready),
        .Enable(enable),
        .Mode  (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < budget);
    endtask

    task automatic wait_enable(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable && n < budget);
    endtask

    task automatic count_enables(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (enable) cnt++;
        end
    endtask

    // Press, then check settle length, first-strobe delay and strobe period.
    task automatic measure_mode(input int exp_mode, input int div);
        int n;
        press();
        chk($sformatf("mode_%0d", exp_mode), 32'(mode), 32'(exp_mode));
        chk($sformatf("rdy_low_%0d", exp_mode), 32'(ready), 0);
        wait_ready(30, n);
        chk($sformatf("settle_%0d", exp_mode), n, 8);
        wait_enable(div + 20, n);
        chk($sformatf("first_en_%0d", exp_mode), n, div);
        wait_enable(div + 20, n);
        chk($sformatf("period_%0d", exp_mode), n, div);
    endtask

    initial begin
        int n;
        int cnt;
        int exp_mode;

        rst_n = 1'b0;
        btn   = 1'b0;
        tick(10);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_enable", 32'(enable), 0);

        rst_n = 1'b1;
        count_enables(10, cnt);
        chk("idle_enables", cnt, 0);
        chk("idle_mode", 32'(mode), 0);
        chk("idle_ready", 32'(ready), 0);

        measure_mode(1, 24);
        count_enables(1000, cnt);
        chk("count_m1", cnt, 41);

        measure_mode(2, 48);
        measure_mode(3, 240);
        count_enables(10000, cnt);
        chk("count_m3", cnt, 41);

        // Ten presses 101 cycles apart, through the wrap; the eleventh lands in measure_mode.
        for (int i = 0; i < 10; i++) begin
            exp_mode = (4 + i) % 10;
            press();
            chk($sformatf("step_mode_%0d", i), 32'(mode), 32'(exp_mode));
            count_enables(100, cnt);
            if (exp_mode == 0) begin
                chk("off_ready", 32'(ready), 0);
                chk("off_enables", cnt, 0);
            end else begin
                chk($sformatf("step_ready_%0d", i), 32'(ready), 1);
            end
        end
        measure_mode(4, 480);

        // Press on the edge where the next mode-4 strobe would fire.
        tick(479);
        press();
        chk("collide_mode", 32'(mode), 5);
        chk("collide_enable", 32'(enable), 0);

        // Press during settle restarts the full settle window.
        tick(3);
        chk("settle_not_ready", 32'(ready), 0);
        press();
        chk("resettle_mode", 32'(mode), 6);
        wait_ready(30, n);
        chk("resettle_len", n, 8);

        // Held button is a single press.
        btn = 1'b1;
        tick(5);
        btn = 1'b0;
        tick(2);
        chk("held_mode", 32'(mode), 7);

        for (int i = 0; i < 8; i++) begin
            press();
            tick(2);
        end
        chk("walk_mode", 32'(mode), 5);
        wait_ready(30, n);
        chk("m5_ready", 32'(ready), 1);
        wait_enable(2420, n);
        chk("m5_first_en", n, 2400);

        tick(100);
        rst_n = 1'b0;
        btn   = 1'b1;
        @(negedge clk);
        chk("midrst_mode", 32'(mode), 0);
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_enable", 32'(enable), 0);
        tick(2);

        // Button already high on the first edge after release counts as a press.
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_press", 32'(mode), 1);
        tick(3);
        chk("post_rst_held", 32'(mode), 1);
        btn = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
